// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline sequencing controller.
package pipe_pkg;

  // Strobe levels for active-low requests and completions
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  // Stage occupancy encoding
  localparam logic FULL  = 1'b1;
  localparam logic EMPTY = 1'b0;

  localparam int unsigned DEF_NUM_STAGES = 4;
  localparam int unsigned DEF_CNT_W      = 16;

  // Width needed to index a stage (at least 1 bit)
  function automatic int unsigned stage_idx_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline stage: holds an occupancy token and decides whether it advances.
module pipe_slot
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_adv,
  input  logic done_n,
  input  logic down_ready,
  input  logic hold,
  input  logic flush,
  output logic occ,
  output logic go,
  output logic adv,
  output logic up_ready
);

  logic occ_nxt;

  // Token leaves when the stage is done and the next stage can take it
  always_comb begin
    adv      = 1'b0;
    up_ready = 1'b0;
    adv      = (done_n == ACTIVE) && (occ == FULL) && !hold && !flush && down_ready;
    up_ready = (occ == EMPTY) || adv;
  end

  // Next occupancy; flush empties the stage regardless of traffic
  always_comb begin
    occ_nxt = occ;
    if (flush) occ_nxt = EMPTY;
    else       occ_nxt = (occ & ~adv) | in_adv;
  end

  // Occupancy register and entry pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ <= EMPTY;
      go  <= 1'b0;
    end else begin
      occ <= occ_nxt;
      go  <= in_adv & ~flush;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// N-stage pipeline sequencing controller: issue, advance, retire, hold, flush.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned NUM_STAGES = DEF_NUM_STAGES,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_n,
  output logic                  issue_ack,
  input  logic [NUM_STAGES-1:0] done_n,
  input  logic                  hold,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] occ,
  output logic [NUM_STAGES-1:0] go,
  output logic                  retire,
  output logic [CNT_W-1:0]      retire_cnt,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned LAST = NUM_STAGES - 1;

  logic acc;
  logic adv_last;
  logic err_hit;

  // Accept a new op when stage 0 is free or emptying; never while in reset
  always_comb begin
    acc       = 1'b0;
    acc       = rst && (issue_n == ACTIVE) && !hold && !flush && g_stage[0].up_ready;
    issue_ack = acc;
  end

  // Stage chain; readiness ripples from the last stage back to stage 0
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    logic in_adv;
    logic down_ready;
    logic adv;
    logic up_ready;

    if (i == 0) begin : g_first
      assign in_adv = acc;
    end else begin : g_next
      assign in_adv = g_stage[i-1].adv;
    end

    if (i == LAST) begin : g_tail
      assign down_ready = 1'b1;
    end else begin : g_body
      assign down_ready = g_stage[i+1].up_ready;
    end

    pipe_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .in_adv     (in_adv),
      .done_n     (done_n[i]),
      .down_ready (down_ready),
      .hold       (hold),
      .flush      (flush),
      .occ        (occ[i]),
      .go         (go[i]),
      .adv        (adv),
      .up_ready   (up_ready)
    );
  end

  assign adv_last = g_stage[LAST].adv;

  // Completion reported by a stage holding no token
  always_comb begin
    err_hit = 1'b0;
    err_hit = !flush && ((~done_n & ~occ) != '0);
  end

  assign busy = |occ;

  // Retire pulse, wrapping retire counter and sticky protocol error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire     <= 1'b0;
      retire_cnt <= '0;
      err        <= 1'b0;
    end else begin
      retire <= adv_last;
      if (adv_last) retire_cnt <= retire_cnt + CNT_W'(1);
      if (err_hit)  err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl against a token-moving reference model.
module tb_pipe_ctrl;

  localparam int NS = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_n;
  logic          issue_ack;
  logic [NS-1:0] done_n;
  logic          hold;
  logic          flush;
  logic [NS-1:0] occ;
  logic [NS-1:0] go;
  logic          retire;
  logic [CW-1:0] retire_cnt;
  logic          busy;
  logic          err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state
  logic [NS-1:0] m_occ;
  logic [NS-1:0] m_go;
  logic          m_ret;
  int            m_cnt;
  logic          m_err;
  // Model prediction for the current inputs
  logic          e_ack;
  logic [NS-1:0] n_occ;
  logic [NS-1:0] n_go;
  logic          n_ret;

  always #5 clk = ~clk;

  pipe_ctrl #(.NUM_STAGES(NS), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_n    (issue_n),
    .issue_ack  (issue_ack),
    .done_n     (done_n),
    .hold       (hold),
    .flush      (flush),
    .occ        (occ),
    .go         (go),
    .retire     (retire),
    .retire_cnt (retire_cnt),
    .busy       (busy),
    .err        (err)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_occ = '0; m_go = '0; m_ret = 1'b0; m_cnt = 0; m_err = 1'b0;
  endtask

  // Move tokens from the retire end backwards into vacated slots, then admit a new op
  task automatic model_eval();
    n_occ = m_occ; n_go = '0; n_ret = 1'b0; e_ack = 1'b0;
    if (flush) begin
      n_occ = '0;
    end else if (!hold) begin
      for (int i = NS - 1; i >= 0; i--) begin
        if (!done_n[i] && m_occ[i]) begin
          if (i == NS - 1) begin
            n_occ[i] = 1'b0; n_ret = 1'b1;
          end else if (!n_occ[i+1]) begin
            n_occ[i] = 1'b0; n_occ[i+1] = 1'b1; n_go[i+1] = 1'b1;
          end
        end
      end
      if (rst && !issue_n && !n_occ[0]) begin
        e_ack = 1'b1; n_occ[0] = 1'b1; n_go[0] = 1'b1;
      end
    end
  endtask

  // Advance one clock; leaves time at the following falling edge
  task automatic step();
    model_eval();
    @(posedge clk);
    for (int i = 0; i < NS; i++)
      if (!flush && !done_n[i] && !m_occ[i]) m_err = 1'b1;
    m_occ = n_occ; m_go = n_go; m_ret = n_ret;
    m_cnt = (m_cnt + (n_ret ? 1 : 0)) % (1 << CW);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; issue_n = 1'b1; done_n = '1; hold = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    done_n = '0; issue_n = 1'b0;
    repeat (5) step();
    issue_n = 1'b1;
    repeat (6) step();
    chk_cnt++;
    if (retire_cnt !== CW'(5)) $display("FAIL reset_precnt: got %0d expected 5", retire_cnt);
    else pass_cnt++;
    issue_n = 1'b0; done_n = 4'b1111; step();
    issue_n = 1'b0; done_n = 4'b1110; step();
    issue_n = 1'b1; done_n = 4'b1100; step();
    issue_n = 1'b1; done_n = 4'b1011; step();
    issue_n = 1'b0; done_n = 4'b1111; step();
    chk_cnt++;
    if (occ !== 4'b1011) $display("FAIL reset_preocc: got %b expected 1011", occ);
    else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk_cnt++;
    if ({occ, go, retire, retire_cnt, err, issue_ack} !== '0)
      $display("FAIL reset_async: got occ=%b go=%b ret=%b cnt=%0d err=%b ack=%b expected all zero",
               occ, go, retire, retire_cnt, err, issue_ack);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (issue_ack !== 1'b1) $display("FAIL reset_first_ack: got %b expected 1", issue_ack);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (occ !== 4'b0001 || go !== 4'b0001)
      $display("FAIL reset_first_op: got occ=%b go=%b expected 0001/0001", occ, go);
    else pass_cnt++;
  endtask

  task automatic test_single_op();
    do_reset();
    done_n = '0; issue_n = 1'b0;
    #1;
    chk_cnt++;
    if (issue_ack !== 1'b1) $display("FAIL single_ack: got %b expected 1", issue_ack);
    else pass_cnt++;
    step();
    issue_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk_cnt++;
      if (go !== NS'(1 << (k - 1)) || retire !== 1'b0)
        $display("FAIL single_go%0d: got go=%b ret=%b expected go=%b ret=0", k, go, retire, NS'(1 << (k - 1)));
      else pass_cnt++;
      step();
    end
    chk_cnt++;
    if (retire !== 1'b1 || retire_cnt !== CW'(1) || busy !== 1'b0 || go !== '0)
      $display("FAIL single_retire: got ret=%b cnt=%0d busy=%b go=%b expected 1/1/0/0000",
               retire, retire_cnt, busy, go);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    do_reset();
    done_n = '0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      issue_n = (cyc < 8) ? 1'b0 : 1'b1;
      #1;
      chk_cnt++;
      if (issue_ack !== (cyc < 8) || retire !== (cyc >= 5 && cyc <= 12))
        $display("FAIL stream_c%0d: got ack=%b ret=%b expected ack=%b ret=%b",
                 cyc, issue_ack, retire, (cyc < 8), (cyc >= 5 && cyc <= 12));
      else pass_cnt++;
      step();
    end
    chk_cnt++;
    if (retire_cnt !== CW'(8)) $display("FAIL stream_cnt: got %0d expected 8", retire_cnt);
    else pass_cnt++;
  endtask

  task automatic test_back_pressure();
    do_reset();
    done_n = 4'b1000; issue_n = 1'b0;
    repeat (6) step();
    #1;
    chk_cnt++;
    if (occ !== 4'b1111 || issue_ack !== 1'b0)
      $display("FAIL bp_full: got occ=%b ack=%b expected 1111/0", occ, issue_ack);
    else pass_cnt++;
    done_n = '0;
    #1;
    chk_cnt++;
    if (issue_ack !== 1'b1) $display("FAIL bp_release_ack: got %b expected 1", issue_ack);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (retire !== 1'b1 || occ !== 4'b1111 || go !== 4'b1111)
      $display("FAIL bp_shift: got ret=%b occ=%b go=%b expected 1/1111/1111", retire, occ, go);
    else pass_cnt++;
  endtask

  task automatic test_hold_flush();
    do_reset();
    issue_n = 1'b0; done_n = 4'b1111; step();
    issue_n = 1'b0; done_n = 4'b1110; step();
    issue_n = 1'b1; done_n = 4'b1100; step();
    chk_cnt++;
    if (occ !== 4'b0110) $display("FAIL hold_setup: got %b expected 0110", occ);
    else pass_cnt++;
    hold = 1'b1; done_n = '0; issue_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_cnt++;
      if (issue_ack !== 1'b0) $display("FAIL hold_ack%0d: got %b expected 0", k, issue_ack);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (occ !== 4'b0110 || go !== '0 || retire !== 1'b0)
        $display("FAIL hold_freeze%0d: got occ=%b go=%b ret=%b expected 0110/0000/0", k, occ, go, retire);
      else pass_cnt++;
    end
    flush = 1'b1;
    step();
    chk_cnt++;
    if (occ !== '0 || go !== '0 || retire !== 1'b0 || retire_cnt !== CW'(0))
      $display("FAIL flush_clear: got occ=%b go=%b ret=%b cnt=%0d expected 0000/0000/0/0",
               occ, go, retire, retire_cnt);
    else pass_cnt++;
    flush = 1'b0; hold = 1'b0; issue_n = 1'b1; done_n = '1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      issue_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) done_n = ~m_occ | NS'($urandom);
      else                           done_n = NS'($urandom);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      model_eval();
      chk_cnt++;
      if (issue_ack !== e_ack)
        $display("FAIL rand_ack c%0d: got %b expected %b", c, issue_ack, e_ack);
      else pass_cnt++;
      step();
      chk_cnt++;
      if (occ !== m_occ || go !== m_go || retire !== m_ret || retire_cnt !== CW'(m_cnt) ||
          err !== m_err || busy !== (m_occ != '0))
        $display("FAIL rand_state c%0d: got occ=%b go=%b ret=%b cnt=%0d err=%b busy=%b expected %b %b %b %0d %b %b",
                 c, occ, go, retire, retire_cnt, err, busy, m_occ, m_go, m_ret, m_cnt, m_err, (m_occ != '0));
      else pass_cnt++;
    end
    hold = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap_err();
    bit seen;
    do_reset();
    for (int c = 0; c < 100 && m_cnt != 15; c++) begin
      issue_n = 1'b0; done_n = ~m_occ;
      step();
    end
    chk_cnt++;
    if (retire_cnt !== CW'(15) || err !== 1'b0)
      $display("FAIL wrap_pre: got cnt=%0d err=%b expected 15/0", retire_cnt, err);
    else pass_cnt++;
    issue_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      done_n = ~m_occ;
      step();
      if (retire === 1'b1) seen = 1'b1;
    end
    chk_cnt++;
    if (!seen || retire_cnt !== CW'(0))
      $display("FAIL wrap_zero: got retire_seen=%b cnt=%0d expected 1/0", seen, retire_cnt);
    else pass_cnt++;
    for (int c = 0; c < 10 && m_occ != '0; c++) begin
      done_n = ~m_occ;
      step();
    end
    done_n = 4'b1011;
    step();
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL err_set: got %b expected 1", err);
    else pass_cnt++;
    done_n = '1;
    repeat (5) step();
    chk_cnt++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b expected 1", err);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b expected 0", err);
    else pass_cnt++;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_streaming();
    test_back_pressure();
    test_hold_flush();
    test_random();
    test_wrap_err();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
